// File: rtl/ntt_job_sequencer_pkg.sv
// Shared types for the NTT job sequencer: sequencer states and transform direction.
package ntt_job_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    UNLOAD
  } seq_state_t;

  typedef enum logic {
    OP_FWD = 1'b0,
    OP_INV = 1'b1
  } ntt_op_t;

endpackage

// File: rtl/ntt_job_sequencer_if.sv
// Job, coefficient stream and engine-side signals of the NTT job sequencer.
interface ntt_job_sequencer_if
  import ntt_job_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  job_valid;
  ntt_op_t               job_op;
  logic                  job_ready;
  logic                  abort;
  logic                  in_valid;
  logic [WIDTH-1:0]      in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic                  out_ready;
  logic                  busy;
  logic                  err_timeout;
  ntt_op_t               eng_sel;
  logic                  eng_load;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [WIDTH-1:0]      eng_wdata;
  logic                  eng_start;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_rdata;

  modport master (
    output job_valid, job_op, abort, in_valid, in_data, out_ready, eng_done, eng_rdata,
    input  job_ready, in_ready, out_valid, out_data, out_last, busy, err_timeout,
           eng_sel, eng_load, eng_addr, eng_wdata, eng_start
  );

  modport slave (
    input  job_valid, job_op, abort, in_valid, in_data, out_ready, eng_done, eng_rdata,
    output job_ready, in_ready, out_valid, out_data, out_last, busy, err_timeout,
           eng_sel, eng_load, eng_addr, eng_wdata, eng_start
  );
endinterface

// File: rtl/ntt_job_sequencer_out_skid.sv
// Two-entry output FIFO for engine read data; grants a read only when a slot
// is guaranteed free by the time the 1-cycle-late data lands.
module ntt_out_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rd_req,
  output logic             rd_issue,
  input  logic [WIDTH-1:0] rdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             inflight;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight;
  // Counting this cycle's pop as a free slot keeps one beat per cycle under full ready.
  assign rd_issue  = rd_req && ((3'(count) + 3'(inflight)) < (3'd2 + 3'(pop)));
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      inflight <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= rd_issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= rdata;
  end
endmodule

// File: rtl/ntt_job_sequencer.sv
// Runs one NTT job: load N coefficients into the engine, start it, wait for done
// under a watchdog, then stream N results out through a skid FIFO.
module ntt_job_sequencer
  import ntt_job_sequencer_pkg::*;
#(
  parameter int N               = 256,
  parameter int WIDTH           = 32,
  parameter int ADDR_WIDTH      = 8,
  parameter int WATCHDOG_CYCLES = 8192
) (
  input logic               clk,
  input logic               rst_n,
  ntt_job_sequencer_if.slave bus
);
  localparam int CW  = ADDR_WIDTH + 1;
  localparam int WDW = $clog2(WATCHDOG_CYCLES) + 1;
  localparam logic [CW-1:0]  LAST    = CW'(N - 1);
  localparam logic [CW-1:0]  COUNT_N = CW'(N);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WATCHDOG_CYCLES - 1);

  seq_state_t       state;
  ntt_op_t          sel;
  logic             err;
  logic [CW-1:0]    ld_cnt;
  logic [CW-1:0]    rd_cnt;
  logic [CW-1:0]    out_cnt;
  logic [WDW-1:0]   wd_cnt;
  logic             in_fire;
  logic             out_fire;
  logic             rd_req;
  logic             rd_issue;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign in_fire  = (state == LOAD) && bus.in_valid;
  assign rd_req   = (state == UNLOAD) && (rd_cnt < COUNT_N);
  assign out_fire = skid_valid && bus.out_ready;

  ntt_out_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.abort),
    .rd_req    (rd_req),
    .rd_issue  (rd_issue),
    .rdata     (bus.eng_rdata),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .out_ready (bus.out_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= OP_FWD;
      err     <= 1'b0;
      ld_cnt  <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
      wd_cnt  <= '0;
    end else if (bus.abort) begin
      state   <= IDLE;
      ld_cnt  <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.job_valid) begin
            sel    <= bus.job_op;
            err    <= 1'b0;
            ld_cnt <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == LAST) state <= START;
          end
        end
        START: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // done arriving on the final watchdog cycle still counts as success
          if (bus.eng_done) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
            state   <= UNLOAD;
          end else if (wd_cnt == WD_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        UNLOAD: begin
          if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
          if (out_fire) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.job_ready   = (state == IDLE);
  assign bus.in_ready    = (state == LOAD);
  assign bus.busy        = (state != IDLE);
  assign bus.eng_start   = (state == START);
  assign bus.eng_sel     = sel;
  assign bus.err_timeout = err;
  assign bus.eng_load    = in_fire;
  assign bus.eng_wdata   = in_fire ? bus.in_data : '0;
  assign bus.eng_addr    = in_fire  ? ld_cnt[ADDR_WIDTH-1:0] :
                           rd_issue ? rd_cnt[ADDR_WIDTH-1:0] : '0;
  assign bus.out_valid   = skid_valid;
  assign bus.out_data    = skid_data;
  assign bus.out_last    = skid_valid && (out_cnt == LAST);
endmodule

// File: tb/tb_ntt_job_sequencer.sv
// Bench for ntt_job_sequencer with a behavioural mod-Q DFT engine behind it.
module tb_ntt_job_sequencer;
  import ntt_job_sequencer_pkg::*;

  localparam int     N     = 256;
  localparam int     WIDTH = 32;
  localparam int     AW    = 8;
  localparam int     WD    = 4400;
  localparam longint Q     = 8380417;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ntt_job_sequencer_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

  ntt_job_sequencer #(
    .N(N), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint powmod(input longint base, input longint e);
    longint r, b, x;
    r = 1;
    b = base % Q;
    x = e;
    while (x > 0) begin
      if (x[0]) r = (r * b) % Q;
      b = (b * b) % Q;
      x = x >>> 1;
    end
    return r;
  endfunction

  // Naive length-N transform; 1753 is a primitive 512th root of unity mod Q.
  function automatic longint dft_point(input longint a [N], input int k, input bit inv);
    longint w, wk, p, acc;
    w = powmod(64'd1753, 64'd2);
    if (inv) w = powmod(w, longint'(N - 1));
    wk  = powmod(w, longint'(k));
    acc = 0;
    p   = 1;
    for (int j = 0; j < N; j++) begin
      acc = (acc + a[j] * p) % Q;
      p   = (p * wk) % Q;
    end
    if (inv) acc = (acc * powmod(longint'(N), Q - 2)) % Q;
    return acc;
  endfunction

  longint eng_mem [N];
  longint eng_res [N];
  int     eng_latency = 30;
  bit     eng_never   = 1'b0;
  bit     eng_busy    = 1'b0;
  int     eng_cnt     = 0;

  always @(posedge clk) begin
    if (bus.eng_load) eng_mem[bus.eng_addr] <= longint'(bus.eng_wdata);
    bus.eng_rdata <= WIDTH'(eng_res[bus.eng_addr]);
    bus.eng_done  <= 1'b0;
    if (bus.eng_start) begin
      for (int k = 0; k < N; k++) eng_res[k] <= dft_point(eng_mem, k, bus.eng_sel == OP_INV);
      eng_busy <= !eng_never;
      eng_cnt  <= 1;
    end else if (eng_busy) begin
      if (eng_cnt >= eng_latency) begin
        bus.eng_done <= 1'b1;
        eng_busy     <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  longint stim [N];
  longint expv [N];

  task automatic randomize_stim();
    for (int i = 0; i < N; i++) stim[i] = longint'($urandom % 32'd8380417);
  endtask

  task automatic fill_expected(input bit inv);
    for (int k = 0; k < N; k++) expv[k] = dft_point(stim, k, inv);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_job_ready"}, 64'(bus.job_ready), 64'd1);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_data"},  64'(bus.out_data),  64'd0);
    check({tag, "_out_last"},  64'(bus.out_last),  64'd0);
    check({tag, "_err"},       64'(bus.err_timeout), 64'd0);
    check({tag, "_eng_sel"},   64'(bus.eng_sel),   64'd0);
    check({tag, "_eng_load"},  64'(bus.eng_load),  64'd0);
    check({tag, "_eng_addr"},  64'(bus.eng_addr),  64'd0);
    check({tag, "_eng_wdata"}, 64'(bus.eng_wdata), 64'd0);
    check({tag, "_eng_start"}, 64'(bus.eng_start), 64'd0);
  endtask

  // mode 0: full job, 1: engine never finishes, 2: async reset during WAIT
  task automatic run_job(input bit op, input int gap_pct, input int stall_pct,
                         input int abort_ld, input int abort_ul, input int mode);
    int beat, idx, cyc, bubbles;
    bit seen, prev_stall;
    logic [WIDTH-1:0] prev_data;

    @(negedge clk);
    check("job_ready_idle", 64'(bus.job_ready), 64'd1);
    bus.job_valid = 1'b1;
    bus.job_op    = ntt_op_t'(op);
    @(negedge clk);
    bus.job_valid = 1'b0;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    check("eng_sel", 64'(bus.eng_sel), 64'(op));
    check("err_cleared_on_accept", 64'(bus.err_timeout), 64'd0);

    beat = 0;
    cyc  = 0;
    while (beat < N) begin
      check("in_ready_load", 64'(bus.in_ready), 64'd1);
      if (beat == abort_ld) begin
        bus.in_valid = 1'b0;
        bus.abort    = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_load_busy", 64'(bus.busy), 64'd0);
        check("abort_load_job_ready", 64'(bus.job_ready), 64'd1);
        check("abort_load_in_ready", 64'(bus.in_ready), 64'd0);
        return;
      end
      bus.in_valid = (int'($urandom_range(99)) >= gap_pct);
      bus.in_data  = WIDTH'(stim[beat]);
      #1;
      check("eng_load", 64'(bus.eng_load), 64'(bus.in_valid));
      check("eng_addr_load", 64'(bus.eng_addr), 64'(bus.in_valid ? beat : 0));
      check("eng_wdata", 64'(bus.eng_wdata), 64'(bus.in_valid ? stim[beat] : 64'd0));
      if (bus.in_valid && bus.in_ready) beat++;
      @(negedge clk);
      cyc++;
      if (cyc > 4 * N) begin
        check("load_cycle_budget", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    check("eng_start_pulse", 64'(bus.eng_start), 64'd1);
    check("in_ready_after_load", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("eng_start_single", 64'(bus.eng_start), 64'd0);

    if (mode == 1) begin
      repeat (WD - 1) @(negedge clk);
      check("wd_last_cycle_busy", 64'(bus.busy), 64'd1);
      check("wd_last_cycle_err", 64'(bus.err_timeout), 64'd0);
      @(negedge clk);
      check("wd_err_timeout", 64'(bus.err_timeout), 64'd1);
      check("wd_job_ready", 64'(bus.job_ready), 64'd1);
      check("wd_busy", 64'(bus.busy), 64'd0);
      return;
    end
    if (mode == 2) begin
      repeat (9) @(negedge clk);
      check("wait_busy_before_reset", 64'(bus.busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end

    idx        = 0;
    cyc        = 0;
    seen       = 1'b0;
    prev_stall = 1'b0;
    bubbles    = 0;
    prev_data  = '0;
    while (idx < N) begin
      if (prev_stall) begin
        check("stall_valid_held", 64'(bus.out_valid), 64'd1);
        check("stall_data_held", 64'(bus.out_data), 64'(prev_data));
      end
      if (bus.out_valid) seen = 1'b1;
      else if (seen) bubbles++;
      if (idx == abort_ul) begin
        bus.out_ready = 1'b0;
        bus.abort     = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_unload_busy", 64'(bus.busy), 64'd0);
        check("abort_unload_flushed", 64'(bus.out_valid), 64'd0);
        check("abort_unload_job_ready", 64'(bus.job_ready), 64'd1);
        return;
      end
      bus.out_ready = (int'($urandom_range(99)) >= stall_pct);
      if (bus.out_valid && bus.out_ready) begin
        check("out_data", 64'(bus.out_data), 64'(expv[idx]));
        check("out_last", 64'(bus.out_last), 64'(idx == N - 1));
        idx++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      @(negedge clk);
      cyc++;
      if (cyc > eng_latency + 8 * N + 50) begin
        check("unload_cycle_budget", 64'd0, 64'd1);
        bus.out_ready = 1'b0;
        return;
      end
    end
    bus.out_ready = 1'b0;
    check("done_busy", 64'(bus.busy), 64'd0);
    check("done_job_ready", 64'(bus.job_ready), 64'd1);
    check("done_out_valid", 64'(bus.out_valid), 64'd0);
    if (stall_pct == 0) check("full_rate_bubbles", 64'(bubbles), 64'd0);
  endtask

  initial begin
    bus.job_valid = 1'b0;
    bus.job_op    = OP_FWD;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) stim[i] = longint'(i);
    fill_expected(1'b0);
    eng_latency = 4352;
    run_job(1'b0, 0, 0, -1, -1, 0);

    for (int i = 0; i < N; i++) begin
      stim[i] = expv[i];
      expv[i] = longint'(i);
    end
    eng_latency = 30;
    run_job(1'b1, 0, 0, -1, -1, 0);

    randomize_stim();
    fill_expected(1'b0);
    run_job(1'b0, 30, 50, -1, -1, 0);
    randomize_stim();
    fill_expected(1'b1);
    run_job(1'b1, 20, 50, -1, -1, 0);

    eng_never = 1'b1;
    randomize_stim();
    run_job(1'b0, 0, 0, -1, -1, 1);
    eng_never = 1'b0;

    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.abort     = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
    bus.abort     = 1'b0;
    check("abort_beats_accept_busy", 64'(bus.busy), 64'd0);
    check("abort_beats_accept_ready", 64'(bus.job_ready), 64'd1);
    check("abort_keeps_err", 64'(bus.err_timeout), 64'd1);

    randomize_stim();
    run_job(1'b0, 10, 0, 37, -1, 0);
    randomize_stim();
    fill_expected(1'b1);
    run_job(1'b1, 10, 30, -1, -1, 0);

    randomize_stim();
    fill_expected(1'b0);
    run_job(1'b0, 0, 50, -1, 200, 0);
    randomize_stim();
    fill_expected(1'b1);
    run_job(1'b1, 0, 0, -1, -1, 0);

    eng_latency = WD - 1;
    randomize_stim();
    fill_expected(1'b0);
    run_job(1'b0, 0, 0, -1, -1, 0);
    check("done_on_last_wd_cycle_no_err", 64'(bus.err_timeout), 64'd0);
    eng_latency = 30;

    randomize_stim();
    run_job(1'b1, 0, 0, -1, -1, 2);
    repeat (40) @(negedge clk);
    randomize_stim();
    fill_expected(1'b1);
    run_job(1'b1, 15, 40, -1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
